// File: rtl/nv_nvdla_gray_ptr_cntr.sv
// nv_nvdla_gray_ptr_cntr: gray-code async-FIFO pointer with peer synchroniser and full/empty flag
// Optional sticky misuse flag enabled by NV_NVDLA_GRAY_PTR_ERR_EN.
module nv_nvdla_gray_ptr_cntr #(
    parameter int AW          = 3,
    parameter int SYNC_STAGES = 2,
    parameter bit IS_WR       = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clr,
    input  logic [AW:0]   peer_gray,
    output logic [AW:0]   gray,
    output logic [AW-1:0] addr,
    output logic          flag,
    output logic          wrap,
    output logic          err
);
    localparam int W = AW + 1;
    localparam logic FLAG_RST = ~IS_WR;
    // Full means the peer pointer with its two MSBs inverted.
    localparam logic [W-1:0] MSK = W'(3) << (W - 2);

    logic [W-1:0] sync [SYNC_STAGES];
    logic [W-1:0] bin, bin_nxt, gray_nxt, peer_s, tgt;
    logic         adv;

    assign adv      = inc & ~flag;
    assign bin_nxt  = bin + W'(adv);
    assign gray_nxt = bin_nxt ^ (bin_nxt >> 1);
    assign peer_s   = sync[SYNC_STAGES-1];
    assign tgt      = IS_WR ? (peer_s ^ MSK) : peer_s;
    assign addr     = bin[AW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
        end else begin
            sync[0] <= peer_gray;
            for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || clr) begin
            bin  <= '0;
            gray <= '0;
            flag <= FLAG_RST;
            wrap <= 1'b0;
        end else begin
            bin  <= bin_nxt;
            gray <= gray_nxt;
            flag <= (gray_nxt == tgt);
            wrap <= adv & (bin == '1);
        end
    end

`ifdef NV_NVDLA_GRAY_PTR_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err <= 1'b0;
        else if (inc && flag)
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_nv_nvdla_gray_ptr_cntr.sv
// tb_nv_nvdla_gray_ptr_cntr: scoreboard bench for write- and read-side gray pointers (AW=2)
module tb_nv_nvdla_gray_ptr_cntr;
`ifdef NV_NVDLA_GRAY_PTR_ERR_EN
    localparam logic EE = 1'b1;
`else
    localparam logic EE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       w_inc, w_clr, r_inc, r_clr;
    logic [2:0] w_peer, r_peer, w_gray, r_gray;
    logic [1:0] w_addr, r_addr;
    logic       w_flag, w_wrap, w_err, r_flag, r_wrap, r_err;
    logic [7:0] wv, rv;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;

    typedef struct {
        int         cyc;
        string      nm;
        bit         wr;
        logic [7:0] v;
    } exp_t;
    exp_t q[$];

    logic [2:0] gs_a [4] = '{3'b001, 3'b011, 3'b010, 3'b110};
    logic [2:0] gs_b [4] = '{3'b111, 3'b101, 3'b100, 3'b000};

    always #5 clk = ~clk;

    assign wv = {w_gray, w_addr, w_flag, w_wrap, w_err};
    assign rv = {r_gray, r_addr, r_flag, r_wrap, r_err};

    nv_nvdla_gray_ptr_cntr #(.AW(2), .SYNC_STAGES(2), .IS_WR(1)) u_wr (
        .clk(clk), .reset(reset), .inc(w_inc), .clr(w_clr), .peer_gray(w_peer),
        .gray(w_gray), .addr(w_addr), .flag(w_flag), .wrap(w_wrap), .err(w_err)
    );

    nv_nvdla_gray_ptr_cntr #(.AW(2), .SYNC_STAGES(2), .IS_WR(0)) u_rd (
        .clk(clk), .reset(reset), .inc(r_inc), .clr(r_clr), .peer_gray(r_peer),
        .gray(r_gray), .addr(r_addr), .flag(r_flag), .wrap(r_wrap), .err(r_err)
    );

    function automatic void chk(string nm, logic [7:0] act, logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: gray/addr/flag/wrap/err got %b required %b", nm, act, req);
        end
    endfunction

    task automatic ex(string nm, bit wr, logic [2:0] g, logic [1:0] a, logic f, logic wp, logic e);
        q.push_back('{cyc + 1, nm, wr, {g, a, f, wp, e}});
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                chk(e.nm, e.wr ? wv : rv, e.v);
            end
        end
    end

    initial begin
        reset = 1'b1;
        {w_inc, w_clr, r_inc, r_clr} = '0;
        w_peer = '0;
        r_peer = '0;
        tick(); tick();
        ex("rst_rd", 0, 3'b000, 2'd0, 1, 0, 0);
        ex("rst_wr", 1, 3'b000, 2'd0, 0, 0, 0);
        tick();
        reset = 1'b0;
        ex("idle_rd", 0, 3'b000, 2'd0, 1, 0, 0);
        tick();
        // write side fills to full
        w_inc = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ex($sformatf("fill%0d", k), 1, gs_a[k], 2'(k + 1), k == 3, 0, 0);
            tick();
        end
        ex("push_on_full", 1, 3'b110, 2'd0, 1, 0, EE);
        tick();
        w_inc = 1'b0;
        w_peer = 3'b001;
        for (int k = 1; k <= 3; k++) begin
            ex($sformatf("full_release%0d", k), 1, 3'b110, 2'd0, k < 3, 0, EE);
            tick();
        end
        w_peer = 3'b110;
        for (int k = 1; k <= 3; k++) begin
            ex($sformatf("peer_move%0d", k), 1, 3'b110, 2'd0, 0, 0, EE);
            tick();
        end
        w_inc = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ex($sformatf("wrapfill%0d", k), 1, gs_b[k], 2'(k + 1), k == 3, k == 3, EE);
            tick();
        end
        w_inc = 1'b0;
        ex("wrap_drop", 1, 3'b000, 2'd0, 1, 0, EE);
        tick();
        w_clr = 1'b1;
        ex("wr_clr", 1, 3'b000, 2'd0, 0, 0, EE);
        tick();
        w_clr = 1'b0;
        ex("wr_after_clr", 1, 3'b000, 2'd0, 1, 0, EE);
        tick();
        // read side: empty releases after peer moves
        r_peer = 3'b001;
        for (int k = 1; k <= 3; k++) begin
            ex($sformatf("empty_release%0d", k), 0, 3'b000, 2'd0, k < 3, 0, 0);
            tick();
        end
        r_inc = 1'b1;
        ex("pop1", 0, 3'b001, 2'd1, 1, 0, 0);
        tick();
        r_inc = 1'b0;
        r_peer = 3'b010;
        for (int k = 1; k <= 3; k++) begin
            ex($sformatf("rd_peer%0d", k), 0, 3'b001, 2'd1, k < 3, 0, 0);
            tick();
        end
        r_inc = 1'b1;
        ex("pop2", 0, 3'b011, 2'd2, 0, 0, 0);
        tick();
        r_clr = 1'b1;
        ex("clr_over_inc", 0, 3'b000, 2'd0, 1, 0, 0);
        tick();
        {r_clr, r_inc} = '0;
        ex("sync_kept", 0, 3'b000, 2'd0, 0, 0, 0);
        tick();
        r_peer = 3'b000;
        for (int k = 1; k <= 3; k++) begin
            ex($sformatf("rd_empty%0d", k), 0, 3'b000, 2'd0, k == 3, 0, 0);
            tick();
        end
        r_inc = 1'b1;
        ex("pop_on_empty", 0, 3'b000, 2'd0, 1, 0, EE);
        tick();
        r_inc = 1'b0;
        r_clr = 1'b1;
        ex("err_thru_clr", 0, 3'b000, 2'd0, 1, 0, EE);
        tick();
        r_clr = 1'b0;
        tick();
        // asynchronous reset between clock edges
        #2 reset = 1'b1;
        #1;
        chk("async_rst_wr", wv, 8'b000_00_0_0_0);
        chk("async_rst_rd", rv, 8'b000_00_1_0_0);
        tick();
        reset = 1'b0;
        tick(); tick();
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover: got %0d pending expectations required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
